// File: rtl/biquad_coeff_loader.sv
// Biquad coefficient loader: host-written staging table replayed into the FIR/IIR/incremental
// coefficient chains, one write every two cycles, followed by a shared commit pulse.
module biquad_coeff_loader #(
    parameter int NENTRY = 16,
    parameter int CBITS  = 18
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NENTRY)-1:0]   host_adr_i,
    input  logic [1:0]                  host_tgt_i,
    input  logic [CBITS-1:0]            host_dat_i,
    input  logic                        host_wr_i,
    input  logic                        start_i,
    input  logic [$clog2(NENTRY):0]     len_i,
    output logic [1:0]                  coeff_adr_o,
    output logic [CBITS-1:0]            coeff_dat_o,
    output logic                        fir_wr_o,
    output logic                        iir_wr_o,
    output logic                        incr_wr_o,
    output logic                        coeff_update_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int AW = $clog2(NENTRY);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        STROBE,
        GAP,
        UPDATE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CBITS+1:0] mem_q [NENTRY];
    logic [AW:0]      idx_q, idx_d;
    logic [AW:0]      len_q, len_d;
    logic [1:0]       adr_q;
    logic [CBITS-1:0] dat_q;
    logic [2:0]       route_q;
    logic             busy_q, update_q, done_q, err_q;
    logic             accept;
    logic             rd_en;
    logic             wr_en;
    logic [CBITS+1:0] rd_word;

    function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
        if (l > (AW+1)'(NENTRY))
            return (AW+1)'(NENTRY);
        return l;
    endfunction

    // One-hot strobe select {incr, iir, fir}; both FIR banks share the FIR strobe.
    function automatic logic [2:0] route_of(input logic [1:0] tgt);
        case (tgt)
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    assign accept  = (state_q == IDLE) && start_i && !rst;
    assign wr_en   = host_wr_i && !busy_q && !rst;
    assign rd_en   = (state_d == STROBE);
    assign rd_word = mem_q[idx_q[AW-1:0]];

    // Staging table: never cleared, so contents survive reset and aborted replays.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[host_adr_i] <= {host_tgt_i, host_dat_i};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = READ;
                    idx_d   = '0;
                    len_d   = clamp_len(len_i);
                end
            end
            READ: begin
                state_d = (len_q == '0) ? UPDATE : STROBE;
            end
            STROBE: begin
                state_d = GAP;
            end
            GAP: begin
                state_d = (idx_q < len_q) ? STROBE : UPDATE;
            end
            UPDATE: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rd_en)
            idx_d = idx_d + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    // Read register doubles as the coefficient output: it loads on entry to STROBE and
    // holds through GAP, so adr/dat stay stable until the next strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q   <= '0;
            dat_q   <= '0;
            route_q <= '0;
        end else begin
            route_q <= '0;
            if (rd_en) begin
                adr_q   <= rd_word[CBITS+1:CBITS];
                dat_q   <= rd_word[CBITS-1:0];
                route_q <= route_of(rd_word[CBITS+1:CBITS]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            update_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            busy_q   <= (state_d == READ) || (state_d == STROBE) ||
                        (state_d == GAP)  || (state_d == UPDATE);
            update_q <= (state_d == UPDATE);
            done_q   <= (state_d == DONE);
            err_q    <= host_wr_i && busy_q;
        end
    end

    assign coeff_adr_o    = adr_q;
    assign coeff_dat_o    = dat_q;
    assign fir_wr_o       = route_q[0];
    assign iir_wr_o       = route_q[1];
    assign incr_wr_o      = route_q[2];
    assign coeff_update_o = update_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Randomized bench for biquad_coeff_loader against a cycle-schedule reference model.
module tb_biquad_coeff_loader;

    localparam int NENTRY = 16;
    localparam int CBITS  = 18;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       host_adr_i = '0;
    logic [1:0]       host_tgt_i = '0;
    logic [17:0]      host_dat_i = '0;
    logic             host_wr_i = 1'b0;
    logic             start_i = 1'b0;
    logic [4:0]       len_i = '0;
    logic [1:0]       coeff_adr_o;
    logic [17:0]      coeff_dat_o;
    logic             fir_wr_o, iir_wr_o, incr_wr_o;
    logic             coeff_update_o, busy_o, done_o, err_o;

    int total = 0;
    int bad   = 0;

    logic [1:0]  m_tgt [NENTRY];
    logic [17:0] m_dat [NENTRY];
    logic [1:0]  exp_adr = '0;
    logic [17:0] exp_dat = '0;

    biquad_coeff_loader #(.NENTRY(NENTRY), .CBITS(CBITS)) dut (
        .clk            (clk),
        .rst            (rst),
        .host_adr_i     (host_adr_i),
        .host_tgt_i     (host_tgt_i),
        .host_dat_i     (host_dat_i),
        .host_wr_i      (host_wr_i),
        .start_i        (start_i),
        .len_i          (len_i),
        .coeff_adr_o    (coeff_adr_o),
        .coeff_dat_o    (coeff_dat_o),
        .fir_wr_o       (fir_wr_o),
        .iir_wr_o       (iir_wr_o),
        .incr_wr_o      (incr_wr_o),
        .coeff_update_o (coeff_update_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {busy_o, done_o, err_o, coeff_update_o, incr_wr_o, iir_wr_o, fir_wr_o};
    endfunction

    task automatic host_write(input int a, input int t, input int d);
        host_adr_i = a[3:0];
        host_tgt_i = t[1:0];
        host_dat_i = d[17:0];
        host_wr_i  = 1'b1;
        step();
        host_wr_i  = 1'b0;
        m_tgt[a]   = t[1:0];
        m_dat[a]   = d[17:0];
    endtask

    // Starts a replay of length L at cycle T and checks every cycle through T+2L'+4.
    // wr_c/st_c/rst_c inject a host write, a second start, or reset at that cycle offset.
    task automatic run_seq(input int L, input bit wr_start, input int wr_c, input int st_c,
                           input int rst_c);
        int          le;
        int          err_c;
        int          k;
        int          wa;
        logic [6:0]  e;
        logic [6:0]  g;
        le    = (L > NENTRY) ? NENTRY : L;
        err_c = -1;
        start_i = 1'b1;
        len_i   = L[4:0];
        if (wr_start) begin
            wa = $urandom_range(0, NENTRY - 1);
            host_adr_i = wa[3:0];
            host_tgt_i = 2'($urandom_range(0, 3));
            host_dat_i = 18'($urandom);
            host_wr_i  = 1'b1;
            m_tgt[wa]  = host_tgt_i;
            m_dat[wa]  = host_dat_i;
        end
        step();
        start_i   = 1'b0;
        host_wr_i = 1'b0;
        for (int c = 1; c <= 2 * le + 4; c++) begin
            if (rst_c >= 0 && c == rst_c + 1) begin
                rst = 1'b0;
                exp_adr = '0;
                exp_dat = '0;
                total++;
                if (outs() !== 7'b0 || coeff_adr_o !== 2'b0 || coeff_dat_o !== 18'b0) begin
                    bad++;
                    $display("FAIL reset_abort c=%0d got=%b/%0h/%0h exp=0", c, outs(),
                             coeff_adr_o, coeff_dat_o);
                end
                step();
                total++;
                if (outs() !== 7'b0) begin
                    bad++;
                    $display("FAIL post_abort_idle got=%b exp=0", outs());
                end
                break;
            end
            e = '0;
            e[6] = (c <= 2 * le + 2);
            e[5] = (c == 2 * le + 3);
            e[4] = (c == err_c);
            e[3] = (c == 2 * le + 2);
            if (c >= 2 && (c % 2) == 0 && (c - 2) / 2 < le) begin
                k = (c - 2) / 2;
                exp_adr = m_tgt[k];
                exp_dat = m_dat[k];
                e[0] = (m_tgt[k] == 2'd0) || (m_tgt[k] == 2'd1);
                e[1] = (m_tgt[k] == 2'd2);
                e[2] = (m_tgt[k] == 2'd3);
            end
            g = outs();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL ctl L=%0d c=%0d got=%b exp=%b", L, c, g, e);
            end
            total++;
            if (coeff_adr_o !== exp_adr) begin
                bad++;
                $display("FAIL adr L=%0d c=%0d got=%0d exp=%0d", L, c, coeff_adr_o, exp_adr);
            end
            total++;
            if (coeff_dat_o !== exp_dat) begin
                bad++;
                $display("FAIL dat L=%0d c=%0d got=%0h exp=%0h", L, c, coeff_dat_o, exp_dat);
            end
            if (c == wr_c) begin
                wa = $urandom_range(0, NENTRY - 1);
                host_adr_i = wa[3:0];
                host_tgt_i = 2'($urandom_range(0, 3));
                host_dat_i = 18'($urandom);
                host_wr_i  = 1'b1;
                if (c <= 2 * le + 2) begin
                    err_c = c + 1;
                end else begin
                    m_tgt[wa] = host_tgt_i;
                    m_dat[wa] = host_dat_i;
                end
            end
            if (c == st_c) begin
                start_i = 1'b1;
                len_i   = 5'($urandom);
            end
            if (c == rst_c)
                rst = 1'b1;
            step();
            host_wr_i = 1'b0;
            start_i   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (outs() !== 7'b0 || coeff_adr_o !== 2'b0 || coeff_dat_o !== 18'b0) begin
            bad++;
            $display("FAIL reset got=%b/%0h/%0h exp=0", outs(), coeff_adr_o, coeff_dat_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill_table();
        for (int i = 0; i < NENTRY; i++)
            host_write(i, $urandom_range(0, 3), $urandom);
    endtask

    task automatic test_fir_load();
        host_write(0, 0, 1);
        host_write(1, 0, 2);
        host_write(2, 0, 1);
        host_write(3, 1, 1);
        host_write(4, 1, 5);
        host_write(5, 1, 4);
        host_write(6, 1, 3);
        run_seq(7, 0, -1, -1, -1);
    endtask

    task automatic test_iir_incr();
        host_write(0, 2, 'h3FFFF);
        host_write(1, 3, 'h00200);
        run_seq(2, 0, -1, -1, -1);
    endtask

    task automatic test_len_bounds();
        run_seq(0, 0, -1, -1, -1);
        test_fill_table();
        run_seq(31, 0, -1, -1, -1);
        run_seq(16, 0, -1, -1, -1);
    endtask

    task automatic test_busy_write_and_start();
        run_seq(7, 0, 5, 5, -1);
        run_seq(7, 0, -1, -1, -1);
    endtask

    task automatic test_reset_abort();
        run_seq(7, 0, -1, -1, 7);
        run_seq(7, 0, -1, -1, -1);
    endtask

    task automatic test_rst_ignores_inputs();
        rst        = 1'b1;
        start_i    = 1'b1;
        len_i      = 5'd4;
        host_adr_i = 4'd1;
        host_tgt_i = 2'd2;
        host_dat_i = ~m_dat[1];
        host_wr_i  = 1'b1;
        step();
        rst = 1'b0;
        start_i = 1'b0;
        host_wr_i = 1'b0;
        exp_adr = '0;
        exp_dat = '0;
        step();
        total++;
        if (outs() !== 7'b0) begin
            bad++;
            $display("FAIL rst_ignore got=%b exp=0", outs());
        end
        run_seq(4, 0, -1, -1, -1);
    endtask

    task automatic test_write_with_start();
        for (int i = 0; i < 3; i++)
            run_seq(4, 1, -1, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_seq(3, 0, -1, 9, -1);
        run_seq(5, 0, -1, -1, -1);
        run_seq(2, 0, -1, -1, -1);
    endtask

    task automatic test_random();
        int l;
        int span;
        for (int i = 0; i < 8; i++) begin
            l = $urandom_range(0, 20);
            span = 2 * ((l > NENTRY) ? NENTRY : l) + 3;
            run_seq(l, 1'($urandom), $urandom_range(1, span), $urandom_range(1, span), -1);
        end
    endtask

    initial begin
        test_reset();
        test_fill_table();
        test_fir_load();
        test_iir_incr();
        test_len_bounds();
        test_busy_write_and_start();
        test_reset_abort();
        test_rst_ignores_inputs();
        test_write_with_start();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
